// File: rtl/connect4_pkg.sv
// Shared Connect Four definitions: board dimensions, cell codes and the
// drop controller state encoding.
package connect4_pkg;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int COL_W = $clog2(COLS);
    localparam int HGT_W = $clog2(ROWS + 1);
    localparam int CNT_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_RED   = 2'b01,
        CELL_GREEN = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_INJECT = 2'b01,
        ST_FALL   = 2'b10,
        ST_SWAP   = 2'b11
    } drop_state_t;

    // Player that moves after p; an unexpected code falls back to green.
    function automatic cell_t other_player(input cell_t p);
        case (p)
            CELL_GREEN: return CELL_RED;
            CELL_RED:   return CELL_GREEN;
            default:    return CELL_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/column_drop_controller_if.sv
// Drop request / board status bundle between the game logic and the
// column drop controller.
interface column_drop_controller_if;
    import connect4_pkg::*;

    logic                drop;
    logic [COL_W-1:0]    col_sel;
    logic                freeze;
    logic [2*COLS-1:0]   top_up;
    logic [1:0]          turn;
    logic [COLS-1:0]     col_full;
    logic                board_full;
    logic                busy;
    logic                reject;

    modport master (
        output drop, col_sel, freeze,
        input  top_up, turn, col_full, board_full, busy, reject
    );

    modport slave (
        input  drop, col_sel, freeze,
        output top_up, turn, col_full, board_full, busy, reject
    );

endinterface

// File: rtl/column_height_counter.sv
// Fill height of one column; saturates at ROWS and flags the column full.
module column_height_counter
    import connect4_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [HGT_W-1:0] height,
    output logic             full
);

    logic [HGT_W-1:0] height_d, height_q;
    logic             full_d, full_q;

    // Next height and full flag, full tracking the height being written.
    always_comb begin
        height_d = height_q;
        if (inc && (height_q < HGT_W'(ROWS))) begin
            height_d = height_q + HGT_W'(1);
        end else begin
            height_d = height_q;
        end
        full_d = (height_d == HGT_W'(ROWS));
    end

    // Height and full registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            height_q <= '0;
            full_q   <= 1'b0;
        end else begin
            height_q <= height_d;
            full_q   <= full_d;
        end
    end

    assign height = height_q;
    assign full   = full_q;

endmodule

// File: rtl/column_drop_controller.sv
// Token injector for the top row of the board: validates drops, injects the
// current player's code and waits for the token to settle before swapping turn.
module column_drop_controller
    import connect4_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    column_drop_controller_if.slave    bus
);

    drop_state_t       state_d, state_q;
    logic [COL_W-1:0]  col_d, col_q;
    logic [CNT_W-1:0]  fall_cnt_d, fall_cnt_q;
    cell_t             turn_d, turn_q;
    logic [2*COLS-1:0] top_up_d, top_up_q;
    logic              busy_d, busy_q;
    logic              reject_d, reject_q;

    logic [HGT_W-1:0]  height_s [COLS];
    logic [COLS-1:0]   col_full_s;
    logic [COLS-1:0]   inc_s;
    logic [HGT_W-1:0]  sel_height_s;
    logic              sel_valid_s;
    logic              drop_ok_s;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign inc_s[c] = (state_q == ST_INJECT) && (col_q == COL_W'(c));

        column_height_counter u_height (
            .clock  (clock),
            .reset  (reset),
            .inc    (inc_s[c]),
            .height (height_s[c]),
            .full   (col_full_s[c])
        );
    end

    // Height of the requested column; out-of-range selects leave sel_valid_s low.
    always_comb begin
        sel_height_s = '0;
        sel_valid_s  = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            sel_height_s = (bus.col_sel == COL_W'(c)) ? height_s[c] : sel_height_s;
            sel_valid_s  = (bus.col_sel == COL_W'(c)) ? 1'b1 : sel_valid_s;
        end
        drop_ok_s = sel_valid_s && (sel_height_s < HGT_W'(ROWS)) && !bus.freeze;
    end

    // Drop sequencing; top_up is prepared one cycle early so it lines up with INJECT.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        fall_cnt_d = fall_cnt_q;
        turn_d     = turn_q;
        top_up_d   = '0;
        reject_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.drop && drop_ok_s) begin
                    state_d    = ST_INJECT;
                    col_d      = bus.col_sel;
                    fall_cnt_d = CNT_W'(ROWS - 1) - CNT_W'(sel_height_s);
                    top_up_d[2*bus.col_sel +: 2] = turn_q;
                end else begin
                    reject_d = bus.drop;
                end
            end
            ST_INJECT: begin
                reject_d = bus.drop;
                if (fall_cnt_q != CNT_W'(0)) begin
                    state_d = ST_FALL;
                end else begin
                    state_d = ST_SWAP;
                end
            end
            ST_FALL: begin
                reject_d   = bus.drop;
                fall_cnt_d = fall_cnt_q - CNT_W'(1);
                if (fall_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_FALL;
                end
            end
            ST_SWAP: begin
                reject_d = bus.drop;
                state_d  = ST_IDLE;
                // A frozen game keeps the winner's colour on turn.
                if (bus.freeze) begin
                    turn_d = turn_q;
                end else begin
                    turn_d = other_player(turn_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            fall_cnt_q <= '0;
            turn_q     <= CELL_GREEN;
            top_up_q   <= '0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            fall_cnt_q <= fall_cnt_d;
            turn_q     <= turn_d;
            top_up_q   <= top_up_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
        end
    end

    assign bus.top_up     = top_up_q;
    assign bus.turn       = turn_q;
    assign bus.busy       = busy_q;
    assign bus.reject     = reject_q;
    assign bus.col_full   = col_full_s;
    assign bus.board_full = &col_full_s;

endmodule

// File: tb/tb_column_drop_controller.sv
// Directed bench for column_drop_controller: a cycle table for a single drop
// and rejects, then hand sequences for filling, freeze, reset and a full board.
module tb_column_drop_controller;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    column_drop_controller_if bus ();

    column_drop_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        drop;
        logic [2:0]  col;
        logic [13:0] top;
        logic [1:0]  turn;
        logic        busy;
        logic        rej;
    } vec_t;

    vec_t tbl [17];
    int   hm [7];
    logic [1:0] turn_m;

    function automatic logic [1:0] flip(input logic [1:0] t);
        return (t == 2'b10) ? 2'b01 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One accepted drop: checks the injected code, busy length and new turn.
    task automatic do_drop(input int col, input logic [1:0] code, input int fall,
                           input logic [1:0] turn_after);
        logic [13:0] e;
        int n;
        e = 14'h0000;
        e[2*col +: 2] = code;
        bus.drop = 1'b1;
        bus.col_sel = 3'(col);
        tick();
        bus.drop = 1'b0;
        chk($sformatf("inject_top_c%0d", col), 32'(bus.top_up), 32'(e));
        chk("inject_rej", 32'(bus.reject), 32'd0);
        n = 1;
        while (bus.busy && n < 30) begin
            tick();
            if (bus.busy) n++;
        end
        chk($sformatf("busy_len_c%0d", col), 32'(n), 32'(fall + 2));
        chk($sformatf("turn_after_c%0d", col), 32'(bus.turn), 32'(turn_after));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        bus.drop = 1'b0;
        bus.col_sel = 3'd0;
        bus.freeze = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_turn", 32'(bus.turn), 32'h2);
        chk("rst_top", 32'(bus.top_up), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rej", 32'(bus.reject), 32'h0);
        chk("rst_colfull", 32'(bus.col_full), 32'h0);
        chk("rst_boardfull", 32'(bus.board_full), 32'h0);

        // Row i: inputs during cycle i, expected outputs in cycle i+1.
        tbl[0]  = '{1'b1, 3'd3, 14'h0080, 2'b10, 1'b1, 1'b0};
        for (int i = 1; i <= 6; i++) tbl[i] = '{1'b0, 3'd0, 14'h0000, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd7, 14'h0000, 2'b01, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'd3, 14'h0040, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 3'd0, 14'h0000, 2'b01, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 14'h0000, 2'b01, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 3'd0, 14'h0000, 2'b10, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            bus.drop = tbl[i].drop;
            bus.col_sel = tbl[i].col;
            tick();
            chk($sformatf("tbl%0d_top", i), 32'(bus.top_up), 32'(tbl[i].top));
            chk($sformatf("tbl%0d_turn", i), 32'(bus.turn), 32'(tbl[i].turn));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_rej", i), 32'(bus.reject), 32'(tbl[i].rej));
        end
        bus.drop = 1'b0;

        // Fill column 0; the rejected drop at row 12 must not have landed.
        turn_m = 2'b10;
        for (int k = 0; k < 6; k++) begin
            do_drop(0, turn_m, 5 - k, flip(turn_m));
            turn_m = flip(turn_m);
        end
        chk("c0_full", 32'(bus.col_full), 32'h01);
        bus.drop = 1'b1;
        bus.col_sel = 3'd0;
        tick();
        bus.drop = 1'b0;
        chk("full_rej", 32'(bus.reject), 32'h1);
        chk("full_rej_top", 32'(bus.top_up), 32'h0);
        chk("full_rej_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("full_rej_pulse", 32'(bus.reject), 32'h0);
        chk("full_rej_turn", 32'(bus.turn), 32'(turn_m));

        // Freeze raised during the fall of a green drop
        bus.drop = 1'b1;
        bus.col_sel = 3'd1;
        tick();
        bus.drop = 1'b0;
        chk("frz_top", 32'(bus.top_up), 32'h0008);
        tick();
        bus.freeze = 1'b1;
        n = 2;
        while (bus.busy && n < 30) begin
            tick();
            if (bus.busy) n++;
        end
        chk("frz_busy_len", 32'(n), 32'd7);
        chk("frz_turn", 32'(bus.turn), 32'h2);
        bus.drop = 1'b1;
        bus.col_sel = 3'd2;
        tick();
        bus.drop = 1'b0;
        chk("frz_rej", 32'(bus.reject), 32'h1);
        chk("frz_rej_busy", 32'(bus.busy), 32'h0);
        bus.freeze = 1'b0;
        tick();
        do_drop(1, 2'b10, 4, 2'b01);

        // Reset in the middle of a fall
        bus.drop = 1'b1;
        bus.col_sel = 3'd2;
        tick();
        bus.drop = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        chk("mrst_top", 32'(bus.top_up), 32'h0);
        chk("mrst_turn", 32'(bus.turn), 32'h2);
        chk("mrst_colfull", 32'(bus.col_full), 32'h0);
        tick();
        chk("mrst_top_quiet", 32'(bus.top_up), 32'h0);
        chk("mrst_busy_quiet", 32'(bus.busy), 32'h0);

        // Heights restart at 0, then fill the whole board.
        do_drop(0, 2'b10, 5, 2'b01);
        for (int c = 0; c < 7; c++) hm[c] = 0;
        hm[0] = 1;
        turn_m = 2'b01;
        for (int c = 0; c < 7; c++) begin
            while (hm[c] < 6) begin
                do_drop(c, turn_m, 5 - hm[c], flip(turn_m));
                turn_m = flip(turn_m);
                hm[c]++;
            end
            if (c == 5) chk("board_not_full", 32'(bus.board_full), 32'h0);
        end
        chk("board_full", 32'(bus.board_full), 32'h1);
        chk("all_cols_full", 32'(bus.col_full), 32'h7f);
        bus.drop = 1'b1;
        bus.col_sel = 3'd6;
        tick();
        bus.drop = 1'b0;
        chk("board_full_rej", 32'(bus.reject), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
